// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | reg_write_arbiter_if                                                  |
// | Writeback requester handshakes and register-bank write port bundle.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface reg_write_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic              Req0Valid;
   logic [ADDR_W-1:0] Req0Reg;
   logic [DATA_W-1:0] Req0Dado;
   logic              Req0Ready;
   logic              Req1Valid;
   logic [ADDR_W-1:0] Req1Reg;
   logic [DATA_W-1:0] Req1Dado;
   logic              Req1Ready;
   logic [ADDR_W-1:0] RegEscr;
   logic [DATA_W-1:0] DadoEscr;
   logic              RegWrite;
   logic              InitDone;

   modport master (
      output Req0Valid, Req0Reg, Req0Dado,
      output Req1Valid, Req1Reg, Req1Dado,
      input  Req0Ready, Req1Ready,
      input  RegEscr, DadoEscr, RegWrite, InitDone
   );

   modport slave (
      input  Req0Valid, Req0Reg, Req0Dado,
      input  Req1Valid, Req1Reg, Req1Dado,
      output Req0Ready, Req1Ready,
      output RegEscr, DadoEscr, RegWrite, InitDone
   );
endinterface
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | reg_write_arbiter                                                     |
// | Sweeps the register bank to INIT_VALUE, then round-robins two         |
// | writeback requesters onto the single bank write port.                 |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module reg_write_arbiter #(
   parameter int                DATA_W     = 8,
   parameter int                ADDR_W     = 3,
   parameter int                NUM_REGS   = 8,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
   input  wire logic          Clock,
   input  wire logic          Reset,
   reg_write_arbiter_if.slave bus
);

   localparam logic [ADDR_W-1:0] c_LAST_REG = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_lastGrant;   // 0 = Req0 won last, 1 = Req1 won last
   logic [ADDR_W-1:0] r_regEscr;
   logic [DATA_W-1:0] r_dadoEscr;
   logic              r_regWrite;
   logic              r_initDone;

   logic              w_grant0;
   logic              w_grant1;

   // Grant depends only on Valids and the pointer, never on Ready itself.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (!Reset && (r_state == ST_RUN)) begin
         if (bus.Req0Valid && bus.Req1Valid) begin
            if (r_lastGrant) begin
               w_grant0 = 1'b1;
            end else begin
               w_grant1 = 1'b1;
            end
         end else if (bus.Req0Valid) begin
            w_grant0 = 1'b1;
         end else if (bus.Req1Valid) begin
            w_grant1 = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state     <= ST_INIT;
         r_cnt       <= '0;
         r_lastGrant <= 1'b1;
         r_regEscr   <= '0;
         r_dadoEscr  <= '0;
         r_regWrite  <= 1'b0;
         r_initDone  <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_regWrite <= 1'b1;
               r_regEscr  <= r_cnt;
               r_dadoEscr <= INIT_VALUE;
               if (r_cnt == c_LAST_REG) begin
                  r_state    <= ST_RUN;
                  r_initDone <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (w_grant0) begin
                  r_regWrite  <= 1'b1;
                  r_regEscr   <= bus.Req0Reg;
                  r_dadoEscr  <= bus.Req0Dado;
                  r_lastGrant <= 1'b0;
               end else if (w_grant1) begin
                  r_regWrite  <= 1'b1;
                  r_regEscr   <= bus.Req1Reg;
                  r_dadoEscr  <= bus.Req1Dado;
                  r_lastGrant <= 1'b1;
               end else begin
                  r_regWrite  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_INIT;
            end
         endcase
      end
   end

   assign bus.Req0Ready = w_grant0;
   assign bus.Req1Ready = w_grant1;
   assign bus.RegEscr   = r_regEscr;
   assign bus.DadoEscr  = r_dadoEscr;
   assign bus.RegWrite  = r_regWrite;
   assign bus.InitDone  = r_initDone;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_reg_write_arbiter                                                  |
// | Directed scenarios plus randomized requesters against a bench model.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_reg_write_arbiter;

   localparam int         NUM  = 8;
   localparam logic [7:0] INIT = 8'h00;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   always #5 Clock = ~Clock;

   reg_write_arbiter_if bus ();

   reg_write_arbiter dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   bit checkEn = 1'b0;

   // bench model state
   bit         mInit = 1'b1;
   int         mCnt  = 0;
   int         mLast = 1;
   bit         mAcc0 = 1'b0;
   bit         mAcc1 = 1'b0;
   bit         eWrite = 1'b0;
   logic [2:0] eReg  = '0;
   logic [7:0] eData = '0;
   bit         eDone = 1'b0;
   logic [7:0] expBank [NUM];
   logic [7:0] dutBank [NUM];
   int         grantLog [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic v0, input logic v1, input int last);
      if (v0 && v1) return (last == 1) ? 0 : 1;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Model: advance on each edge, and let both banks commit what was presented.
   initial forever begin
      int w;
      @(posedge Clock);
      if (bus.RegWrite === 1'b1) dutBank[bus.RegEscr] = bus.DadoEscr;
      if (eWrite) expBank[eReg] = eData;
      mAcc0 = 1'b0;
      mAcc1 = 1'b0;
      if (Reset) begin
         mInit = 1'b1; mCnt = 0; mLast = 1;
         eWrite = 1'b0; eReg = '0; eData = '0; eDone = 1'b0;
      end else if (mInit) begin
         eWrite = 1'b1;
         eReg   = 3'(mCnt);
         eData  = INIT;
         mCnt++;
         if (mCnt == NUM) begin
            mInit = 1'b0;
            eDone = 1'b1;
         end
      end else begin
         w = pick(bus.Req0Valid, bus.Req1Valid, mLast);
         if (w == 0) begin
            eWrite = 1'b1; eReg = bus.Req0Reg; eData = bus.Req0Dado; mAcc0 = 1'b1;
         end else if (w == 1) begin
            eWrite = 1'b1; eReg = bus.Req1Reg; eData = bus.Req1Dado; mAcc1 = 1'b1;
         end else begin
            eWrite = 1'b0;
         end
         if (w >= 0) begin
            mLast = w;
            grantLog.push_back(w);
         end
      end
   end

   // Compare every cycle, away from the active edge.
   initial forever begin
      int w;
      @(negedge Clock);
      if (checkEn) begin
         w = (Reset || mInit) ? -1 : pick(bus.Req0Valid, bus.Req1Valid, mLast);
         chk("Req0Ready", bus.Req0Ready, w == 0);
         chk("Req1Ready", bus.Req1Ready, w == 1);
         chk("RegWrite",  bus.RegWrite,  eWrite);
         chk("RegEscr",   bus.RegEscr,   eReg);
         chk("DadoEscr",  bus.DadoEscr,  eData);
         chk("InitDone",  bus.InitDone,  eDone);
      end
   end

   task automatic resetSweep();
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
      repeat (NUM) tick();
   endtask

   initial begin
      bus.Req0Valid = 1'b0; bus.Req0Reg = '0; bus.Req0Dado = '0;
      bus.Req1Valid = 1'b0; bus.Req1Reg = '0; bus.Req1Dado = '0;

      // 1: reset two cycles, then the eight-write sweep
      Reset = 1'b1;
      tick();
      checkEn = 1'b1;
      chk("rst_RegWrite", bus.RegWrite, 0);
      chk("rst_InitDone", bus.InitDone, 0);
      tick();
      Reset = 1'b0;
      for (int i = 0; i < NUM; i++) begin
         tick();
         #1;
         chk("sweep_RegWrite", bus.RegWrite, 1);
         chk("sweep_RegEscr",  bus.RegEscr, i);
         chk("sweep_DadoEscr", bus.DadoEscr, 0);
         chk("sweep_InitDone", bus.InitDone, (i == NUM - 1));
      end
      tick();
      for (int i = 0; i < NUM; i++) chk("bank_zero", dutBank[i], 0);

      // 2: single requester
      bus.Req0Valid = 1'b1; bus.Req0Reg = 3'd3; bus.Req0Dado = 8'hA5;
      #1;
      chk("t2_Req0Ready", bus.Req0Ready, 1);
      chk("t2_Req1Ready", bus.Req1Ready, 0);
      tick();
      bus.Req0Valid = 1'b0;
      #1;
      chk("t2_RegWrite", bus.RegWrite, 1);
      chk("t2_RegEscr",  bus.RegEscr, 3);
      chk("t2_DadoEscr", bus.DadoEscr, 8'hA5);
      tick();
      chk("t2_bank3", dutBank[3], 8'hA5);

      // 3: both held four cycles from a fresh pointer
      resetSweep();
      grantLog.delete();
      bus.Req0Valid = 1'b1; bus.Req0Reg = 3'd1; bus.Req0Dado = 8'h11;
      bus.Req1Valid = 1'b1; bus.Req1Reg = 3'd2; bus.Req1Dado = 8'h22;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 3) begin
            bus.Req0Valid = 1'b0;
            bus.Req1Valid = 1'b0;
         end
         #1;
         chk("t3_RegWrite", bus.RegWrite, 1);
         chk("t3_RegEscr",  bus.RegEscr, (k % 2 == 0) ? 1 : 2);
      end
      chk("t3_grants", grantLog.size(), 4);
      if (grantLog.size() == 4) begin
         chk("t3_g0", grantLog[0], 0);
         chk("t3_g1", grantLog[1], 1);
         chk("t3_g2", grantLog[2], 0);
         chk("t3_g3", grantLog[3], 1);
      end

      // 4: same target on the first tie
      resetSweep();
      bus.Req0Valid = 1'b1; bus.Req0Reg = 3'd5; bus.Req0Dado = 8'h55;
      bus.Req1Valid = 1'b1; bus.Req1Reg = 3'd5; bus.Req1Dado = 8'h66;
      tick();
      bus.Req0Valid = 1'b0;
      #1;
      chk("t4_first", bus.DadoEscr, 8'h55);
      tick();
      bus.Req1Valid = 1'b0;
      #1;
      chk("t4_second", bus.DadoEscr, 8'h66);
      tick();
      chk("t4_bank5", dutBank[5], 8'h66);

      // 5: reset at sweep step 4 restarts the sweep
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
      repeat (4) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      #1;
      chk("t5_RegWrite", bus.RegWrite, 0);
      chk("t5_InitDone", bus.InitDone, 0);
      tick();
      #1;
      chk("t5_restart", bus.RegEscr, 0);
      repeat (6) tick();
      chk("t5_notdone", bus.InitDone, 0);
      tick();
      chk("t5_done", bus.InitDone, 1);
      chk("t5_last", bus.RegEscr, 7);

      // 6: request held through the sweep
      Reset = 1'b1;
      bus.Req0Valid = 1'b1; bus.Req0Reg = 3'd6; bus.Req0Dado = 8'h3C;
      tick();
      tick();
      Reset = 1'b0;
      for (int i = 0; i < NUM; i++) begin
         #1;
         chk("t6_init_ready", bus.Req0Ready, 0);
         tick();
      end
      #1;
      chk("t6_run_ready", bus.Req0Ready, 1);
      tick();
      bus.Req0Valid = 1'b0;
      #1;
      chk("t6_RegEscr", bus.RegEscr, 6);
      chk("t6_DadoEscr", bus.DadoEscr, 8'h3C);

      // randomized requesters with occasional reset
      for (int n = 0; n < 600; n++) begin
         tick();
         Reset = ($urandom_range(0, 99) == 0);
         if (mAcc0 || !bus.Req0Valid) begin
            bus.Req0Valid = ($urandom_range(0, 2) != 0);
            bus.Req0Reg   = 3'($urandom);
            bus.Req0Dado  = 8'($urandom);
         end
         if (mAcc1 || !bus.Req1Valid) begin
            bus.Req1Valid = ($urandom_range(0, 2) != 0);
            bus.Req1Reg   = 3'($urandom);
            bus.Req1Dado  = 8'($urandom);
         end
      end
      Reset = 1'b0;
      bus.Req0Valid = 1'b0;
      bus.Req1Valid = 1'b0;
      repeat (12) tick();
      for (int i = 0; i < NUM; i++) chk("final_bank", dutBank[i], expBank[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
